// File: rtl/dvi_capture_pkg.sv
// Shared types and defaults for the DVI/VGA capture path.
// Optional build macro: DVI_CAP_STATS_EN (line/frame statistics outputs).
package dvi_capture_pkg;

   localparam int unsigned H_ACT_DEF  = 640;
   localparam int unsigned V_ACT_DEF  = 480;
   localparam int unsigned CNT_W      = 12;
   localparam int unsigned STAT_W     = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_CAPTURE = 2'd2
   } cap_state_e;

   // Number of words stored per decimated frame.
   function automatic int unsigned frame_words(input int unsigned h, input int unsigned v);
      return (h / 2) * (v / 2);
   endfunction

endpackage

// File: rtl/dvi_capture_sync_edge.sv
// Input register stage for the capture path plus vsync-assertion and de-fall detection.
module dvi_capture_sync_edge #(
   parameter int unsigned DATA_W   = 24,
   parameter int unsigned SYNC_POL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              de_in,
   input  logic [DATA_W-1:0] pix_in,
   output logic              hs_s1,
   output logic              de_s1,
   output logic [DATA_W-1:0] pix_s1,
   output logic              vs_edge_c,
   output logic              de_fall_c
);

   localparam logic VS_ACT = 1'(SYNC_POL);

   logic              hs1_q, hs1_d;
   logic              vs1_q, vs1_d;
   logic              vs2_q, vs2_d;
   logic              de1_q, de1_d;
   logic              de2_q, de2_d;
   logic [DATA_W-1:0] pix1_q, pix1_d;

   always_comb begin
      hs1_d  = hsync_in;
      vs1_d  = vsync_in;
      vs2_d  = vs1_q;
      de1_d  = de_in;
      de2_d  = de1_q;
      pix1_d = pix_in;
   end

   // Reset sync stages to their deasserted level so no edge fires out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         hs1_q  <= ~VS_ACT;
         vs1_q  <= ~VS_ACT;
         vs2_q  <= ~VS_ACT;
         de1_q  <= 1'b0;
         de2_q  <= 1'b0;
         pix1_q <= '0;
      end else begin
         hs1_q  <= hs1_d;
         vs1_q  <= vs1_d;
         vs2_q  <= vs2_d;
         de1_q  <= de1_d;
         de2_q  <= de2_d;
         pix1_q <= pix1_d;
      end
   end

   assign hs_s1     = hs1_q;
   assign de_s1     = de1_q;
   assign pix_s1    = pix1_q;
   assign vs_edge_c = (vs1_q == VS_ACT) && (vs2_q != VS_ACT);
   assign de_fall_c = de2_q && !de1_q;

endmodule

// File: rtl/dvi_capture.sv
// 640x480 DVI/VGA capture: 2:1 decimation in X and Y into ping-pong frame RAM banks.
// Optional build macro: DVI_CAP_STATS_EN adds line_len / frame_lines outputs.
module dvi_capture
   import dvi_capture_pkg::*;
#(
   parameter int unsigned H_ACT    = H_ACT_DEF,
   parameter int unsigned V_ACT    = V_ACT_DEF,
   parameter int unsigned SYNC_POL = 0,
   parameter int unsigned ADDR_W   = 17,
   parameter int unsigned DATA_W   = 24
) (
   input  logic              clk_25M,
   input  logic              rst,
   input  logic              arm,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              de_in,
   input  logic [DATA_W-1:0] pix_in,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_bank,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err
`ifdef DVI_CAP_STATS_EN
   ,
   output logic [STAT_W-1:0] line_len,
   output logic [STAT_W-1:0] frame_lines
`endif
);

   localparam int unsigned ADDR_MAX = frame_words(H_ACT, V_ACT) - 1;

   logic              hs_s1, de_s1, vs_edge_c, de_fall_c;
   logic [DATA_W-1:0] pix_s1;
   logic              unused_hs;

   dvi_capture_sync_edge #(
      .DATA_W   (DATA_W),
      .SYNC_POL (SYNC_POL)
   ) u_sync_edge (
      .clk       (clk_25M),
      .rst       (rst),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .de_in     (de_in),
      .pix_in    (pix_in),
      .hs_s1     (hs_s1),
      .de_s1     (de_s1),
      .pix_s1    (pix_s1),
      .vs_edge_c (vs_edge_c),
      .de_fall_c (de_fall_c)
   );

   // Framing is de-based; hsync is sampled but deliberately not consumed.
   assign unused_hs = hs_s1;

   cap_state_e        state_q, state_d;
   logic [CNT_W-1:0]  x_q, x_d;
   logic [CNT_W-1:0]  y_q, y_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              bank_q, bank_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ferr_q, ferr_d;

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      err_d     = err_q;
      addr_d    = addr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      bank_d    = bank_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (arm) state_d = ST_WAIT_VS;
         end
         ST_WAIT_VS: begin
            if (!arm) begin
               state_d = ST_IDLE;
            end else if (vs_edge_c) begin
               state_d = ST_CAPTURE;
               x_d     = '0;
               y_d     = '0;
               addr_d  = '0;
               err_d   = 1'b0;
            end
         end
         ST_CAPTURE: begin
            if (!arm) begin
               state_d = ST_IDLE;
            end else if (vs_edge_c) begin
               // End of frame takes priority over any pixel in the same cycle.
               if ((y_q == CNT_W'(V_ACT)) && !err_q) begin
                  done_d = 1'b1;
                  bank_d = ~bank_q;
               end else begin
                  ferr_d = 1'b1;
               end
               x_d    = '0;
               y_d    = '0;
               addr_d = '0;
               err_d  = 1'b0;
            end else if (de_fall_c) begin
               if (x_q != CNT_W'(H_ACT)) err_d = 1'b1;
               x_d = '0;
               if (y_q != '1) y_d = y_q + CNT_W'(1);
            end else if (de_s1) begin
               if (!x_q[0] && !y_q[0] && (x_q < CNT_W'(H_ACT)) && (y_q < CNT_W'(V_ACT))) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = pix_s1;
                  if (addr_q != ADDR_W'(ADDR_MAX)) addr_d = addr_q + ADDR_W'(1);
               end
               if (x_q != '1) x_d = x_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_25M) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         bank_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         bank_q    <= bank_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign wr_bank    = bank_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign frame_err  = ferr_q;

`ifdef DVI_CAP_STATS_EN
   logic [STAT_W-1:0] line_len_q, line_len_d;
   logic [STAT_W-1:0] frame_lines_q, frame_lines_d;

   // Statistics only follow edges seen while capturing.
   always_comb begin
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      if (state_q == ST_CAPTURE) begin
         if (de_fall_c) line_len_d = STAT_W'(x_q);
         if (vs_edge_c) frame_lines_d = STAT_W'(y_q);
      end
   end

   always_ff @(posedge clk_25M) begin
      if (rst) begin
         line_len_q    <= '0;
         frame_lines_q <= '0;
      end else begin
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
      end
   end

   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;
`endif

endmodule

// File: tb/tb_dvi_capture.sv
// Bench for dvi_capture at a reduced 16x8 raster: frame scenario table plus arm-drop and reset sequences.
module tb_dvi_capture;

   localparam int unsigned H    = 16;
   localparam int unsigned V    = 8;
   localparam int unsigned AW   = 17;
   localparam int unsigned DW   = 24;
   localparam int unsigned MAXA = (H / 2) * (V / 2) - 1;

   logic          clk = 1'b0;
   logic          rst, arm, hs, vs, de;
   logic [DW-1:0] pix;
   logic          wr_en, wr_bank, busy, frame_done, frame_err;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
`ifdef DVI_CAP_STATS_EN
   logic [9:0]    line_len, frame_lines;
`endif

   always #5 clk = ~clk;

   dvi_capture #(
      .H_ACT(H), .V_ACT(V), .SYNC_POL(0), .ADDR_W(AW), .DATA_W(DW)
   ) dut (
      .clk_25M    (clk),
      .rst        (rst),
      .arm        (arm),
      .hsync_in   (hs),
      .vsync_in   (vs),
      .de_in      (de),
      .pix_in     (pix),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_bank    (wr_bank),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_err  (frame_err)
`ifdef DVI_CAP_STATS_EN
      ,
      .line_len   (line_len),
      .frame_lines(frame_lines)
`endif
   );

   typedef struct {
      int unsigned   cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      int   nlines;
      int   bad_line;
      int   bad_len;
      int   exp_done;
      int   exp_err;
      logic exp_bank;
   } frame_vec_t;

   int unsigned cyc = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   wr_t         exp_q[$];
   wr_t         obs_q[$];
   int          tests = 0;
   int          fails = 0;
   int          model_addr;
   bit          model_on;

   always @(posedge clk) cyc <= cyc + 1;

   // Write/pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en === 1'b1) obs_q.push_back('{cyc, wr_addr, wr_data});
      if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
      if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one active line; the model predicts each decimated write and its cycle.
   task automatic send_line(input int y, input int len, input int drop_at);
      for (int x = 0; x < len; x++) begin
         @(negedge clk);
         if (x == drop_at) begin
            arm      = 1'b0;
            model_on = 1'b0;
         end
         de  = 1'b1;
         hs  = 1'b1;
         pix = DW'($urandom);
         if (model_on && (x % 2 == 0) && (y % 2 == 0) && (x < int'(H)) && (y < int'(V))) begin
            exp_q.push_back('{cyc + 2, AW'(model_addr), pix});
            if (model_addr < int'(MAXA)) model_addr++;
         end
         if (x == drop_at) begin
            @(negedge clk);
            check("arm_drop_wr_en", 64'(wr_en), 64'(0));
            check("arm_drop_busy", 64'(busy), 64'(0));
         end
      end
      for (int b = 0, n = $urandom_range(3, 6); b < n; b++) begin
         @(negedge clk);
         de = 1'b0;
         hs = (b < 2) ? 1'b0 : 1'b1;
      end
   endtask

   task automatic send_frame(input int nlines, input int bad_line, input int bad_len);
      model_addr = 0;
      for (int y = 0; y < nlines; y++)
         send_line(y, (y == bad_line) ? bad_len : int'(H), -1);
   endtask

   task automatic vsync_pulse();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         de = 1'b0;
         vs = (i < 3) ? 1'b0 : 1'b1;
      end
   endtask

   task automatic compare_writes(input string name);
      int unsigned mx;
      mx = 0;
      check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         if (int'(obs_q[i].addr) > int'(mx)) mx = obs_q[i].addr;
         check({name, "_cyc"}, 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
         check({name, "_addr"}, 64'(obs_q[i].addr), 64'(exp_q[i].addr));
         check({name, "_data"}, 64'(obs_q[i].data), 64'(exp_q[i].data));
      end
      tests++;
      if (mx > MAXA) begin
         fails++;
         $display("FAIL %s_addr_cap: got %0d limit %0d", name, mx, MAXA);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      frame_vec_t tbl[7];
      int d0, e0;

      tbl[0] = '{V,      -1, H,      1, 0, 1'b1};
      tbl[1] = '{V,       2, H - 3,  0, 1, 1'b1};
      tbl[2] = '{V + 2,  -1, H,      0, 1, 1'b1};
      tbl[3] = '{V,      -1, H,      1, 0, 1'b0};
      tbl[4] = '{V,       0, H + 1,  0, 1, 1'b0};
      tbl[5] = '{V - 1,  -1, H,      0, 1, 1'b0};
      tbl[6] = '{V,       3, H - 1,  0, 1, 1'b0};

      rst = 1'b1; arm = 1'b0; hs = 1'b1; vs = 1'b1; de = 1'b0; pix = '0;
      model_on = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_wr_en", 64'(wr_en), 64'(0));
      check("rst_wr_addr", 64'(wr_addr), 64'(0));
      check("rst_wr_data", 64'(wr_data), 64'(0));
      check("rst_wr_bank", 64'(wr_bank), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(frame_done), 64'(0));
      check("rst_err", 64'(frame_err), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'(0));
      arm = 1'b1;
      @(negedge clk);
      check("armed_busy", 64'(busy), 64'(1));

      vsync_pulse();
      check("start_no_pulse", 64'(done_cnt + err_cnt), 64'(0));
      obs_q.delete();

      for (int i = 0; i < 7; i++) begin
         d0 = done_cnt;
         e0 = err_cnt;
         send_frame(tbl[i].nlines, tbl[i].bad_line, tbl[i].bad_len);
         vsync_pulse();
         check($sformatf("vec%0d_done", i), 64'(done_cnt - d0), 64'(tbl[i].exp_done));
         check($sformatf("vec%0d_err", i), 64'(err_cnt - e0), 64'(tbl[i].exp_err));
         check($sformatf("vec%0d_bank", i), 64'(wr_bank), 64'(tbl[i].exp_bank));
         compare_writes($sformatf("vec%0d", i));
      end

      // Make the bank non-zero before the reset sequence.
      d0 = done_cnt;
      send_frame(V, -1, H);
      vsync_pulse();
      check("pre_arm_drop_done", 64'(done_cnt - d0), 64'(1));
      compare_writes("pre_arm_drop");

      // Arm falls in the middle of line 2.
      d0 = done_cnt;
      e0 = err_cnt;
      model_addr = 0;
      send_line(0, H, -1);
      send_line(1, H, -1);
      send_line(2, H, 4);
      for (int y = 3; y < int'(V); y++) send_line(y, H, -1);
      vsync_pulse();
      check("arm_drop_pulses", 64'((done_cnt - d0) + (err_cnt - e0)), 64'(0));
      check("arm_drop_bank", 64'(wr_bank), 64'(1));
      check("arm_drop_idle_busy", 64'(busy), 64'(0));
      compare_writes("arm_drop");

      // Reset mid-capture, then resume on the next vsync.
      arm = 1'b1;
      model_on = 1'b1;
      vsync_pulse();
      model_addr = 0;
      send_line(0, H, -1);
      send_line(1, H, -1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_wr_en", 64'(wr_en), 64'(0));
      check("midrst_wr_addr", 64'(wr_addr), 64'(0));
      check("midrst_wr_data", 64'(wr_data), 64'(0));
      check("midrst_bank", 64'(wr_bank), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_done", 64'(frame_done), 64'(0));
      check("midrst_err", 64'(frame_err), 64'(0));
      compare_writes("pre_rst");
      d0 = done_cnt;
      e0 = err_cnt;
      model_on = 1'b0;
      for (int y = 2; y < int'(V); y++) send_line(y, H, -1);
      check("post_rst_no_writes", 64'(obs_q.size()), 64'(0));
      model_on = 1'b1;
      vsync_pulse();
      check("resume_no_pulse", 64'((done_cnt - d0) + (err_cnt - e0)), 64'(0));
      check("resume_busy", 64'(busy), 64'(1));
      send_frame(V, -1, H);
      vsync_pulse();
      check("resume_done", 64'(done_cnt - d0), 64'(1));
      check("resume_bank", 64'(wr_bank), 64'(1));
      compare_writes("resume");
`ifdef DVI_CAP_STATS_EN
      check("stats_line_len", 64'(line_len), 64'(H));
      check("stats_frame_lines", 64'(frame_lines), 64'(V));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
